// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its write-side loader.
//   IMEM_BYTES      : default instruction memory capacity in bytes
//   loader_state_t  : states of the framed-stream loader FSM
package imem_pkg;

  localparam int unsigned IMEM_BYTES = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: accepts a framed byte stream (LEN_LO, LEN_HI, 4*LEN payload bytes, CSUM)
// and writes each payload byte into the byte-addressable imem, little-endian, starting at
// BASE_ADDR. The core is held in reset until a frame with a matching XOR checksum loads.
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   start            one-cycle pulse arming a new frame (ignored while a frame is active)
//   s_valid/s_data   stream byte in; s_ready out, transfer on s_valid && s_ready
//   mem_we/addr/wdata registered byte write port to imem
//   busy             frame in progress
//   done / err       sticky result of the last frame
//   words_loaded     complete 32-bit words written in the current/last frame
//   cpu_hold         core reset hold, released only after a successful load
//
// state   | meaning
// IDLE    | nothing loaded since reset
// LEN_LO  | waiting for length low byte
// LEN_HI  | waiting for length high byte, range check on handshake
// DATA    | writing payload bytes
// CSUM    | waiting for checksum byte
// DONE    | image loaded and verified, core released
// ERR     | frame rejected, core held
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = IMEM_BYTES,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded,
  output logic        cpu_hold
);

  localparam logic [17:0] MEM_BYTES_W = 18'(MEM_BYTES);

  loader_state_t state_q, state_d;
  logic [7:0]    len_lo_q;
  logic [17:0]   total_q;
  logic [17:0]   byte_cnt_q;
  logic [7:0]    acc_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic [15:0]   words_q;

  logic          hs;
  logic          start_accept;
  logic [15:0]   len_full;
  logic [17:0]   len_bytes;
  logic          last_byte;

  // 4*LEN is formed at 18 bits so the largest LEN (0xFFFF) cannot wrap under the limit.
  assign len_full  = {s_data, len_lo_q};
  assign len_bytes = {len_full, 2'b00};
  assign last_byte = (byte_cnt_q == (total_q - 18'd1));
  assign hs        = s_valid && s_ready;
  assign start_accept = start &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        s_ready = 1'b1;
        if (s_valid) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (len_bytes > MEM_BYTES_W) state_d = ST_ERR;
          else if (len_full == 16'd0)  state_d = ST_CSUM;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        s_ready = 1'b1;
        if (s_valid && last_byte) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        s_ready = 1'b1;
        if (s_valid) state_d = (s_data == acc_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= 8'd0;
      total_q     <= 18'd0;
      byte_cnt_q  <= 18'd0;
      acc_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 8'd0;
      words_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= 1'b0;

      if (start_accept) begin
        words_q    <= 16'd0;
        byte_cnt_q <= 18'd0;
        acc_q      <= 8'd0;
      end

      if (hs && (state_q == ST_LEN_LO)) len_lo_q <= s_data;
      if (hs && (state_q == ST_LEN_HI)) total_q  <= len_bytes;

      if (hs && (state_q == ST_DATA)) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= BASE_ADDR + {14'd0, byte_cnt_q};
        mem_wdata_q <= s_data;
        acc_q       <= acc_q ^ s_data;
        byte_cnt_q  <= byte_cnt_q + 18'd1;
        if (byte_cnt_q[1:0] == 2'd3) words_q <= words_q + 16'd1;
      end
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;
  assign busy         = s_ready;
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERR);
  assign cpu_hold     = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;
  logic        cpu_hold;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct packed {
    logic [0:11][7:0] b;
    logic [7:0]       n;
    logic             gaps;
    logic             exp_done;
    logic             exp_err;
    logic [15:0]      exp_words;
    logic [15:0]      exp_writes;
  } vec_t;

  wr_t        sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         wr_cnt = 0;
  logic [7:0] mem_model [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest pending expected write.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
        mem_model[mem_addr[6:0]] = mem_wdata;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'hxx;
      end
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("s_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_stream();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
  endtask

  vec_t vecs [8];

  initial begin
    logic [15:0] len;
    logic [7:0]  acc;
    logic [7:0]  d;
    bit          len_ok;

    vecs[0] = '{b: {8'h02,8'h00,8'h93,8'h00,8'hf0,8'h00,8'h13,8'h01,8'h60,8'h01,8'h10,8'h00},
                n: 8'd11, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd2, exp_writes: 16'd8};
    vecs[1] = '{b: {8'h02,8'h00,8'h93,8'h00,8'hf0,8'h00,8'h13,8'h01,8'h60,8'h01,8'h10,8'h00},
                n: 8'd11, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd2, exp_writes: 16'd8};
    vecs[2] = '{b: {8'h02,8'h00,8'h93,8'h00,8'hf0,8'h00,8'h13,8'h01,8'h60,8'h01,8'h11,8'h00},
                n: 8'd11, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd2, exp_writes: 16'd8};
    vecs[3] = '{b: {8'h21,8'h00,80'h0},
                n: 8'd2, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0, exp_writes: 16'd0};
    vecs[4] = '{b: {8'h00,8'h00,8'h00,72'h0},
                n: 8'd3, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd0, exp_writes: 16'd0};
    vecs[5] = '{b: {8'h00,8'h00,8'h01,72'h0},
                n: 8'd3, gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0, exp_writes: 16'd0};
    vecs[6] = '{b: {8'hff,8'hff,80'h0},
                n: 8'd2, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0, exp_writes: 16'd0};
    vecs[7] = '{b: {8'h00,8'h40,80'h0},
                n: 8'd2, gaps: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0, exp_writes: 16'd0};

    for (int i = 0; i < 128; i++) mem_model[i] = 8'h00;

    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    @(negedge clk);
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      len    = {vecs[v].b[1], vecs[v].b[0]};
      len_ok = ({2'b00, len, 2'b00} <= 20'd128);
      wr_cnt = 0;
      pulse_start();
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_done_clr", {31'd0, done}, 32'd0);
      check("start_hold", {31'd0, cpu_hold}, 32'd1);
      for (int i = 0; i < 12; i++) begin
        if (i < int'(vecs[v].n)) begin
          if (len_ok && i >= 2 && i < 2 + 4 * int'(len))
            sb.push_back('{addr: 32'(i - 2), data: vecs[v].b[i]});
          send(vecs[v].b[i], vecs[v].gaps);
        end
      end
      idle_stream();
      check("done", {31'd0, done}, {31'd0, vecs[v].exp_done});
      check("err", {31'd0, err}, {31'd0, vecs[v].exp_err});
      check("busy_end", {31'd0, busy}, 32'd0);
      check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !vecs[v].exp_done});
      check("words_loaded", {16'd0, words_loaded}, {16'd0, vecs[v].exp_words});
      repeat (2) @(negedge clk);
      check("write_count", wr_cnt, {16'd0, vecs[v].exp_writes});
      check("sb_drained", sb.size(), 32'd0);
      if (v == 0) begin
        check("imem_word0", {mem_model[3], mem_model[2], mem_model[1], mem_model[0]}, 32'h00f00093);
        check("imem_word4", {mem_model[7], mem_model[6], mem_model[5], mem_model[4]}, 32'h01600113);
      end
      check("sticky_done", {31'd0, done}, {31'd0, vecs[v].exp_done});
    end

    // Largest image that fits exactly, with a stray start mid-payload that must be ignored.
    wr_cnt = 0;
    acc    = 8'h00;
    pulse_start();
    send(8'h20, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 128; i++) begin
      d = 8'(i * 7 + 3);
      acc ^= d;
      sb.push_back('{addr: 32'(i), data: d});
      if (i == 10) begin
        idle_stream();
        pulse_start();
      end
      send(d, 1'b0);
    end
    send(acc, 1'b0);
    idle_stream();
    check("full_done", {31'd0, done}, 32'd1);
    check("full_words", {16'd0, words_loaded}, 32'd32);
    repeat (2) @(negedge clk);
    check("full_writes", wr_cnt, 32'd128);

    // Reset after three payload bytes, then a clean reload.
    wr_cnt = 0;
    pulse_start();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    sb.push_back('{addr: 32'd0, data: 8'h93});
    send(8'h93, 1'b0);
    sb.push_back('{addr: 32'd1, data: 8'h00});
    send(8'h00, 1'b0);
    sb.push_back('{addr: 32'd2, data: 8'hf0});
    send(8'hf0, 1'b0);
    @(negedge clk);
    #2;
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    check("midrst_writes", wr_cnt, 32'd3);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) sb.push_back('{addr: 32'(i), data: vecs[0].b[i + 2]});
    pulse_start();
    for (int i = 0; i < 11; i++) send(vecs[0].b[i], 1'b1);
    idle_stream();
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_words", {16'd0, words_loaded}, 32'd2);
    repeat (2) @(negedge clk);
    check("reload_sb", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
